// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache store buffer.
// Holds default sizing, the reference entry layout and the byte-lane merge helper.
package cache_pkg;

    localparam int CACHE_SBUF_DEPTH_DEF = 4;
    localparam int CACHE_SBUF_AW_DEF    = 32;
    localparam int CACHE_SBUF_DW_DEF    = 32;
    localparam int CACHE_SBUF_BEW_DEF   = CACHE_SBUF_DW_DEF / 8;

    typedef struct packed {
        logic                          valid;
        logic [CACHE_SBUF_AW_DEF-1:0]  addr;
        logic [CACHE_SBUF_DW_DEF-1:0]  data;
        logic [CACHE_SBUF_BEW_DEF-1:0] be;
    } sbuf_entry_t;

    // One byte lane of a merge: returns {be, data}. New bytes win where enabled.
    function automatic logic [8:0] be_merge(
        input logic [7:0] old_data,
        input logic       old_be,
        input logic [7:0] new_data,
        input logic       new_be
    );
        logic [8:0] res;
        if (new_be) begin
            res = {1'b1, new_data};
        end else begin
            res = {old_be, old_data};
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_sbuf_fwd.sv
// Store-to-load forwarding selector: per byte lane, the youngest valid entry
// whose address matches and whose byte enable is set supplies the byte.
module cache_sbuf_fwd #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic                     ent_valid [DEPTH],
    input  logic [AW-1:0]            ent_addr  [DEPTH],
    input  logic [DW-1:0]            ent_data  [DEPTH],
    input  logic [DW/8-1:0]          ent_be    [DEPTH],
    input  logic [AW-1:0]            lk_addr,
    output logic [DW/8-1:0]          lk_mask,
    output logic [DW-1:0]            lk_data
);

    localparam int PW  = $clog2(DEPTH);
    localparam int BEW = DW / 8;

    logic [PW-1:0] idx_s;
    logic          hit_s;

    // Walk entries oldest to youngest from head so younger matches overwrite older ones.
    always_comb begin
        lk_mask = '0;
        lk_data = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = head + PW'(k);
            for (int b = 0; b < BEW; b++) begin
                hit_s = ent_valid[idx_s] && (ent_addr[idx_s] == lk_addr) && ent_be[idx_s][b];
                lk_mask[b]        = lk_mask[b] | hit_s;
                lk_data[8*b +: 8] = hit_s ? ent_data[idx_s][8*b +: 8] : lk_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/cache_store_buf.sv
// In-order store buffer with byte enables, valid/ready drain and RAW forwarding.
// Optional feature macro: CACHE_SBUF_COALESCE_EN (merge writes into the youngest entry).
module cache_store_buf
    import cache_pkg::*;
#(
    parameter int DEPTH = CACHE_SBUF_DEPTH_DEF,
    parameter int AW    = CACHE_SBUF_AW_DEF,
    parameter int DW    = CACHE_SBUF_DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic [DW/8-1:0]        wr_be,
    input  logic [AW-1:0]          lk_addr,
    output logic                   lk_hit,
    output logic [DW/8-1:0]        lk_mask,
    output logic [DW-1:0]          lk_data,
    output logic                   dr_valid,
    input  logic                   dr_ready,
    output logic [AW-1:0]          dr_addr,
    output logic [DW-1:0]          dr_data,
    output logic [DW/8-1:0]        dr_be,
    input  logic                   flush,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int BEW = DW / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Same layout as cache_pkg::sbuf_entry_t, resized to this instance.
    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [BEW-1:0] be;
    } entry_t;

    entry_t         ent_r [DEPTH];
    logic [PW-1:0]  head_r;
    logic [PW-1:0]  tail_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic           full_s;
    logic           empty_s;
    logic           pop_s;
    logic           push_s;
    logic           alloc_s;
    logic           merge_hit_s;
    logic           ent_valid_s [DEPTH];
    logic [AW-1:0]  ent_addr_s  [DEPTH];
    logic [DW-1:0]  ent_data_s  [DEPTH];
    logic [BEW-1:0] ent_be_s    [DEPTH];

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == '0);
    assign pop_s   = !empty_s && dr_ready;

`ifdef CACHE_SBUF_COALESCE_EN
    logic [PW-1:0]  young_s;
    logic [DW-1:0]  merged_data_s;
    logic [BEW-1:0] merged_be_s;
    logic           merge_s;

    assign young_s = tail_r - PTR_ONE;
    // A lone entry that is leaving this cycle cannot absorb the write.
    assign merge_hit_s = !empty_s && ent_r[young_s].valid && (ent_r[young_s].addr == wr_addr)
                         && !(pop_s && (count_r == CNT_ONE));
    assign merge_s = push_s && merge_hit_s;

    // Byte-lane merge of the incoming write over the youngest entry.
    always_comb begin
        merged_data_s = '0;
        merged_be_s   = '0;
        for (int b = 0; b < BEW; b++) begin
            {merged_be_s[b], merged_data_s[8*b +: 8]} =
                be_merge(ent_r[young_s].data[8*b +: 8], ent_r[young_s].be[b],
                         wr_data[8*b +: 8], wr_be[b]);
        end
    end
`else
    assign merge_hit_s = 1'b0;
`endif

    assign wr_ready = (!full_s || merge_hit_s) && !flush;
    assign push_s   = wr_valid && wr_ready;
    assign alloc_s  = push_s && !merge_hit_s;

    // Occupancy update.
    always_comb begin
        case ({alloc_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage and pointers; head and tail never collide on a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (pop_s) begin
                ent_r[head_r].valid <= 1'b0;
                head_r              <= head_r + PTR_ONE;
            end
            if (alloc_s) begin
                ent_r[tail_r] <= '{valid: 1'b1, addr: wr_addr, data: wr_data, be: wr_be};
                tail_r        <= tail_r + PTR_ONE;
            end
`ifdef CACHE_SBUF_COALESCE_EN
            if (merge_s) begin
                ent_r[young_s].data <= merged_data_s;
                ent_r[young_s].be   <= merged_be_s;
            end
`endif
            count_r <= count_nxt_s;
        end
    end

    // Flatten entries for the forwarding selector.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_s[i] = ent_r[i].valid;
            ent_addr_s[i]  = ent_r[i].addr;
            ent_data_s[i]  = ent_r[i].data;
            ent_be_s[i]    = ent_r[i].be;
        end
    end

    // Head entry drives the drain port; zero while empty.
    always_comb begin
        if (empty_s) begin
            dr_addr = '0;
            dr_data = '0;
            dr_be   = '0;
        end else begin
            dr_addr = ent_r[head_r].addr;
            dr_data = ent_r[head_r].data;
            dr_be   = ent_r[head_r].be;
        end
    end

    assign dr_valid = !empty_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign lk_hit   = |lk_mask;

    cache_sbuf_fwd #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .head      (head_r),
        .ent_valid (ent_valid_s),
        .ent_addr  (ent_addr_s),
        .ent_data  (ent_data_s),
        .ent_be    (ent_be_s),
        .lk_addr   (lk_addr),
        .lk_mask   (lk_mask),
        .lk_data   (lk_data)
    );

endmodule

// File: tb/tb_cache_store_buf.sv
// Self-checking bench for cache_store_buf: vector table plus drain scoreboard.
module tb_cache_store_buf;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BEW = 4;
`ifdef CACHE_SBUF_COALESCE_EN
    localparam bit CO = 1'b1;
`else
    localparam bit CO = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           wr_valid;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [BEW-1:0] wr_be;
    logic [AW-1:0]  lk_addr;
    logic           lk_hit;
    logic [BEW-1:0] lk_mask;
    logic [DW-1:0]  lk_data;
    logic           dr_valid;
    logic           dr_ready;
    logic [AW-1:0]  dr_addr;
    logic [DW-1:0]  dr_data;
    logic [BEW-1:0] dr_be;
    logic           flush;
    logic           empty;
    logic [2:0]     count;

    cache_store_buf #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_mask  (lk_mask),
        .lk_data  (lk_data),
        .dr_valid (dr_valid),
        .dr_ready (dr_ready),
        .dr_addr  (dr_addr),
        .dr_data  (dr_data),
        .dr_be    (dr_be),
        .flush    (flush),
        .empty    (empty),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [BEW-1:0] be;
    } exp_t;

    typedef struct {
        logic           wv;
        logic [AW-1:0]  wa;
        logic [DW-1:0]  wd;
        logic [BEW-1:0] wb;
        logic           dr;
        logic [AW-1:0]  la;
        logic [2:0]     cnt;
        logic           hit;
        logic [BEW-1:0] mask;
        logic [DW-1:0]  ld;
        logic           wrdy;
    } vec_t;

    exp_t sb[$];
    vec_t vt [12];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model the handshakes of the current cycle, then advance one clock.
    task automatic cycle();
        exp_t e;
        bit   popping;
        bit   merge_ok;
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            popping  = dr_valid && dr_ready;
            merge_ok = CO && (sb.size() > 0) && (sb[$].addr == wr_addr) && !(popping && sb.size() == 1);
            if (popping) begin
                chk("drain_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("dr_addr", dr_addr, e.addr);
                    chk("dr_data", dr_data, e.data);
                    chk("dr_be", dr_be, e.be);
                end
            end
            if (wr_valid && wr_ready) begin
                if (merge_ok) begin
                    e = sb.pop_back();
                    for (int b = 0; b < BEW; b++) begin
                        if (wr_be[b]) e.data[8*b +: 8] = wr_data[8*b +: 8];
                    end
                    e.be = e.be | wr_be;
                    sb.push_back(e);
                end else begin
                    e.addr = wr_addr;
                    e.data = wr_data;
                    e.be   = wr_be;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] b);
        bit acc = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = b;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1;
            acc = wr_ready;
            cycle();
        end
        wr_valid = 1'b0;
        chk($sformatf("push_%0h_accepted", a), acc, 1);
    endtask

    task automatic drain_all(input string name);
        dr_ready = 1'b1;
        wr_valid = 1'b0;
        for (int n = 0; n < 12 && !empty; n++) cycle();
        #1;
        chk({name, "_empty"}, empty, 1);
        chk({name, "_sb_empty"}, sb.size(), 0);
        dr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 32'h1F0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h1F0, 3'd0, 1'b0, 4'h0, 32'h0, 1'b1};
        vt[1]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h1F0, 3'd1, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1};
        vt[2]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h1F1, 3'd1, 1'b0, 4'h0, 32'h0, 1'b1};
        vt[3]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1F0, 3'd1, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1};
        vt[4]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h1F0, 3'd0, 1'b0, 4'h0, 32'h0, 1'b1};
        vt[5]  = '{1'b1, 32'h1F0, 32'h11111111, 4'hF, 1'b0, 32'h1F0, 3'd0, 1'b0, 4'h0, 32'h0, 1'b1};
        vt[6]  = '{1'b1, 32'h1F0, 32'hCAFEBABE, 4'h3, 1'b0, 32'h1F0, 3'd1, 1'b1, 4'hF, 32'h11111111, 1'b1};
        vt[7]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h1F0, (CO ? 3'd1 : 3'd2), 1'b1, 4'hF, 32'h1111BABE, 1'b1};
        vt[8]  = '{1'b1, 32'h2A0, 32'h55667788, 4'h4, 1'b0, 32'h2A0, (CO ? 3'd1 : 3'd2), 1'b0, 4'h0, 32'h0, 1'b1};
        vt[9]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h2A0, (CO ? 3'd2 : 3'd3), 1'b1, 4'h4, 32'h00660000, 1'b1};
        vt[10] = '{1'b1, 32'h2B0, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h2B0, (CO ? 3'd2 : 3'd3), 1'b0, 4'h0, 32'h0, 1'b1};
        vt[11] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h2B0, (CO ? 3'd3 : 3'd4), 1'b0, 4'h0, 32'h0, (CO ? 1'b1 : 1'b0)};

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        lk_addr = '0; dr_ready = 1'b0; flush = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_dr_valid", dr_valid, 0);
        chk("rst_lk_hit", lk_hit, 0);
        chk("rst_lk_mask", lk_mask, 0);
        chk("rst_lk_data", lk_data, 0);
        chk("rst_dr_addr", dr_addr, 0);
        chk("rst_dr_data", dr_data, 0);
        chk("rst_dr_be", dr_be, 0);

        for (int i = 0; i < 12; i++) begin
            wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].wb;
            dr_ready = vt[i].dr; lk_addr = vt[i].la;
            #1;
            chk($sformatf("v%0d_count", i), count, vt[i].cnt);
            chk($sformatf("v%0d_lk_hit", i), lk_hit, vt[i].hit);
            chk($sformatf("v%0d_lk_mask", i), lk_mask, vt[i].mask);
            chk($sformatf("v%0d_lk_data", i), lk_data, vt[i].ld);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, vt[i].wrdy);
            cycle();
        end
        drain_all("table");

        // Fill to full, check no bypass, then refill across the pointer wrap.
        for (int i = 0; i < 4; i++) push_wait(32'h100 + i, 32'hA0 + i, 4'hF);
        wr_addr = 32'h200;
        #1;
        chk("full_wr_ready", wr_ready, 0);
        chk("full_count", count, 4);
        wr_valid = 1'b1; wr_addr = 32'h104; dr_ready = 1'b1;
        #1;
        chk("full_no_bypass", wr_ready, 0);
        wr_valid = 1'b0;
        cycle();
        chk("after_pop_count", count, 3);
        chk("after_pop_wr_ready", wr_ready, 1);
        for (int i = 4; i < 8; i++) push_wait(32'h100 + i, 32'hA0 + i, 4'hF);
        drain_all("wrap");

        // Flush: writes held off while both entries drain in order.
        push_wait(32'h1F0, 32'hA, 4'hF);
        push_wait(32'h1F1, 32'hB, 4'hF);
        flush = 1'b1; dr_ready = 1'b1; wr_valid = 1'b1; wr_addr = 32'h1F2; wr_data = 32'hC;
        #1;
        chk("flush_wr_ready0", wr_ready, 0);
        chk("flush_head0", dr_addr, 32'h1F0);
        cycle();
        chk("flush_wr_ready1", wr_ready, 0);
        chk("flush_head1", dr_addr, 32'h1F1);
        cycle();
        chk("flush_empty", empty, 1);
        chk("flush_wr_ready2", wr_ready, 0);
        wr_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_release", wr_ready, 1);
        chk("flush_sb_empty", sb.size(), 0);
        dr_ready = 1'b0;

        // Reset with pending entries discards them.
        for (int i = 0; i < 3; i++) push_wait(32'h300 + i, 32'h77 + i, 4'hF);
        #1;
        chk("pre_rst_count", count, 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        lk_addr = 32'h300;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_dr_valid", dr_valid, 0);
        chk("mid_rst_lk_hit0", lk_hit, 0);
        chk("mid_rst_empty", empty, 1);
        lk_addr = 32'h302;
        #1;
        chk("mid_rst_lk_hit2", lk_hit, 0);

        // Head being drained still forwards this cycle, not the next.
        push_wait(32'h1F0, 32'h12345678, 4'hF);
        dr_ready = 1'b1; lk_addr = 32'h1F0;
        #1;
        chk("pop_fwd_hit", lk_hit, 1);
        chk("pop_fwd_data", lk_data, 32'h12345678);
        cycle();
        dr_ready = 1'b0;
        #1;
        chk("post_pop_hit", lk_hit, 0);
        chk("post_pop_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
